axi_slave_protocol_monitor: RTL and testbench

- Passive, synthesizable monitor for one AXI4 slave port (single ID, burst traffic); drives no bus signal.
- Observes AW/W/B/AR/R channels and flags violations on per-check fire outputs plus one sticky summary flag.
- Covers handshake timing (AW, AR), data-increment pattern (W, R), forbidden AR/R overlap, WLAST/RLAST beat count, and write/read phase ordering.
- Sits beside the slave in simulation and in on-chip debug builds.

---
 rtl/axi_slave_protocol_monitor_if.sv | 31 +++
 rtl/axi_slave_protocol_monitor.sv | 198 +++++++++++++++++++
 tb/tb_axi_slave_protocol_monitor.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_protocol_monitor_if.sv
// rtl/axi_slave_protocol_monitor_if.sv - AXI4 slave-port signal bundle observed by the protocol monitor
interface axi_slave_protocol_monitor_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic              AWVALID, AWREADY;
  logic [LEN_W-1:0]  AWLEN;
  logic              WVALID, WREADY, WLAST;
  logic [DATA_W-1:0] WDATA;
  logic              BVALID, BREADY;
  logic              ARVALID, ARREADY;
  logic [LEN_W-1:0]  ARLEN;
  logic              RVALID, RREADY, RLAST;
  logic [DATA_W-1:0] RDATA;

  modport master (
    output AWVALID, AWLEN, WVALID, WLAST, WDATA, BREADY, ARVALID, ARLEN, RREADY,
    input  AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, RDATA
  );

  modport slave (
    input  AWVALID, AWLEN, WVALID, WLAST, WDATA, BREADY, ARVALID, ARLEN, RREADY,
    output AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, RDATA
  );

  // Passive view: the monitor never drives the bus.
  modport monitor (
    input AWVALID, AWREADY, AWLEN, WVALID, WREADY, WLAST, WDATA, BVALID, BREADY,
          ARVALID, ARREADY, ARLEN, RVALID, RREADY, RLAST, RDATA
  );
endinterface

// File: rtl/axi_slave_protocol_monitor.sv
// rtl/axi_slave_protocol_monitor.sv - passive AXI4 slave protocol monitor with registered per-check fires
module axi_slave_protocol_monitor_hs #(
  parameter int MIN_ACK = 1,
  parameter int MAX_ACK = 32
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic valid,
  input  logic ready,
  output logic err
);
  localparam int CW = $clog2(MAX_ACK + 2) + 1;

  logic [CW-1:0] cnt, cnt_now;
  logic          pending, timed_out, ready_q, hs_q;

  always_comb begin
    cnt_now = pending ? cnt + 1'b1 : CW'(1);
    err     = 1'b0;
    if (ready && !valid) err = 1'b1;
    if (pending && !valid && !timed_out) err = 1'b1;
    if (valid && ready && !timed_out &&
        (cnt_now < CW'(MIN_ACK) || cnt_now > CW'(MAX_ACK))) err = 1'b1;
    if (valid && !ready && !timed_out && cnt_now == CW'(MAX_ACK + 1)) err = 1'b1;
    if (ready_q && ready) err = 1'b1;
    if (hs_q && valid) err = 1'b1;
  end

  // After a timeout the request is ignored until VALID drops.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cnt       <= '0;
      pending   <= 1'b0;
      timed_out <= 1'b0;
      ready_q   <= 1'b0;
      hs_q      <= 1'b0;
    end else begin
      ready_q <= ready;
      hs_q    <= valid && ready;
      pending <= valid && !ready;
      if (!valid) timed_out <= 1'b0;
      else if (!ready && !timed_out && cnt_now == CW'(MAX_ACK + 1)) timed_out <= 1'b1;
      if (valid && !timed_out) cnt <= cnt_now;
    end
  end
endmodule

module axi_slave_protocol_monitor_inc #(
  parameter int DATA_W  = 32,
  parameter int INC_VAL = 1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              restart,
  input  logic              beat,
  input  logic [DATA_W-1:0] data,
  output logic              err
);
  logic              have_prev;
  logic [DATA_W-1:0] prev;

  assign err = beat && !restart && have_prev && (data != prev + DATA_W'(INC_VAL));

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      have_prev <= 1'b0;
      prev      <= '0;
    end else if (restart) begin
      have_prev <= 1'b0;
    end else if (beat) begin
      have_prev <= 1'b1;
      prev      <= data;
    end
  end
endmodule

module axi_slave_protocol_monitor_beats #(
  parameter int LEN_W = 8
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             beat,
  input  logic             last,
  output logic             err
);
  logic [LEN_W-1:0] cnt;

  assign err = beat && !load && ((cnt == '0) != last);

  always_ff @(posedge ACLK) begin
    if (!ARESETN)                 cnt <= '0;
    else if (load)                cnt <= len;
    else if (beat && cnt != '0)   cnt <= cnt - 1'b1;
  end
endmodule

module axi_slave_protocol_monitor #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int INC_VAL = 1,
  parameter int MIN_ACK = 1,
  parameter int MAX_ACK = 32
) (
  input  logic ACLK,
  input  logic ARESETN,
  axi_slave_protocol_monitor_if.monitor bus,
  output logic fire_aw_hs,
  output logic fire_ar_hs,
  output logic fire_wdata,
  output logic fire_rdata,
  output logic fire_ar_never,
  output logic fire_wlast,
  output logic fire_rlast,
  output logic fire_wphase,
  output logic fire_rphase,
  output logic err_sticky
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic aw_hs, ar_hs, w_beat, r_beat;
  logic e_aw_hs, e_ar_hs, e_wdata, e_rdata, e_ar_never, e_wlast, e_rlast, e_wphase, e_rphase;
  logic [8:0] err_now, fire_q;
  logic sticky_q;
  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  assign aw_hs  = bus.AWVALID && bus.AWREADY;
  assign ar_hs  = bus.ARVALID && bus.ARREADY;
  assign w_beat = bus.WVALID && bus.WREADY;
  assign r_beat = bus.RVALID && bus.RREADY;
  assign e_ar_never = bus.ARREADY && (bus.RVALID || bus.RREADY || bus.RLAST);

  axi_slave_protocol_monitor_hs #(.MIN_ACK(MIN_ACK), .MAX_ACK(MAX_ACK)) u_aw_hs (
    .ACLK(ACLK), .ARESETN(ARESETN), .valid(bus.AWVALID), .ready(bus.AWREADY), .err(e_aw_hs));
  axi_slave_protocol_monitor_hs #(.MIN_ACK(MIN_ACK), .MAX_ACK(MAX_ACK)) u_ar_hs (
    .ACLK(ACLK), .ARESETN(ARESETN), .valid(bus.ARVALID), .ready(bus.ARREADY), .err(e_ar_hs));
  axi_slave_protocol_monitor_inc #(.DATA_W(DATA_W), .INC_VAL(INC_VAL)) u_w_inc (
    .ACLK(ACLK), .ARESETN(ARESETN), .restart(aw_hs), .beat(w_beat), .data(bus.WDATA), .err(e_wdata));
  axi_slave_protocol_monitor_inc #(.DATA_W(DATA_W), .INC_VAL(INC_VAL)) u_r_inc (
    .ACLK(ACLK), .ARESETN(ARESETN), .restart(ar_hs), .beat(r_beat), .data(bus.RDATA), .err(e_rdata));
  axi_slave_protocol_monitor_beats #(.LEN_W(LEN_W)) u_w_beats (
    .ACLK(ACLK), .ARESETN(ARESETN), .load(aw_hs), .len(bus.AWLEN), .beat(w_beat),
    .last(bus.WLAST), .err(e_wlast));
  axi_slave_protocol_monitor_beats #(.LEN_W(LEN_W)) u_r_beats (
    .ACLK(ACLK), .ARESETN(ARESETN), .load(ar_hs), .len(bus.ARLEN), .beat(r_beat),
    .last(bus.RLAST), .err(e_rlast));

  // A phase violation holds the FSM in place so the error keeps reporting.
  always_comb begin
    w_next   = w_state;
    e_wphase = 1'b0;
    case (w_state)
      W_IDLE:  if (bus.AWREADY && bus.BREADY) e_wphase = 1'b1;
               else if (aw_hs) w_next = W_DATA;
      W_DATA:  if (bus.BREADY) e_wphase = 1'b1;
               else if (w_beat && bus.WLAST) w_next = W_RESP;
      W_RESP:  if (bus.AWREADY || bus.WVALID || bus.WREADY || bus.WLAST) e_wphase = 1'b1;
               else if (bus.BVALID && bus.BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next   = r_state;
    e_rphase = 1'b0;
    case (r_state)
      R_IDLE:  if (e_ar_never) e_rphase = 1'b1;
               else if (ar_hs) r_next = R_DATA;
      R_DATA:  if (bus.ARREADY) e_rphase = 1'b1;
               else if (r_beat && bus.RLAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign err_now = {e_aw_hs, e_ar_hs, e_wdata, e_rdata, e_ar_never,
                    e_wlast, e_rlast, e_wphase, e_rphase};

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      fire_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      w_state  <= w_next;
      r_state  <= r_next;
      fire_q   <= err_now;
      sticky_q <= sticky_q || (|err_now);
    end
  end

  assign {fire_aw_hs, fire_ar_hs, fire_wdata, fire_rdata, fire_ar_never,
          fire_wlast, fire_rlast, fire_wphase, fire_rphase} = fire_q;
  assign err_sticky = sticky_q;
endmodule

// File: tb/tb_axi_slave_protocol_monitor.sv
// tb/tb_axi_slave_protocol_monitor.sv - randomized scenario bench with per-cycle expected fires
module tb_axi_slave_protocol_monitor;
  localparam int MAX_ACK = 32;
  localparam int INC     = 1;
  localparam int F_AWHS = 8, F_ARHS = 7, F_WD = 6, F_RD = 5, F_ARN = 4;
  localparam int F_WL = 3, F_RL = 2, F_WPH = 1, F_RPH = 0;

  typedef struct {
    logic        rstn;
    logic        awvalid, awready; logic [7:0] awlen;
    logic        wvalid, wready, wlast; logic [31:0] wdata;
    logic        bvalid, bready;
    logic        arvalid, arready; logic [7:0] arlen;
    logic        rvalid, rready, rlast; logic [31:0] rdata;
    logic [8:0]  exp;
  } stim_t;

  logic ACLK, ARESETN;
  logic fire_aw_hs, fire_ar_hs, fire_wdata, fire_rdata, fire_ar_never;
  logic fire_wlast, fire_rlast, fire_wphase, fire_rphase, err_sticky;
  int   n_run, n_fail;
  stim_t q[$];

  axi_slave_protocol_monitor_if #(.DATA_W(32), .LEN_W(8)) bus ();

  axi_slave_protocol_monitor #(.DATA_W(32), .LEN_W(8), .INC_VAL(INC), .MIN_ACK(1), .MAX_ACK(MAX_ACK)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus),
    .fire_aw_hs(fire_aw_hs), .fire_ar_hs(fire_ar_hs), .fire_wdata(fire_wdata),
    .fire_rdata(fire_rdata), .fire_ar_never(fire_ar_never), .fire_wlast(fire_wlast),
    .fire_rlast(fire_rlast), .fire_wphase(fire_wphase), .fire_rphase(fire_rphase),
    .err_sticky(err_sticky));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle_cycle();
    stim_t s;
    s = '{default: 0};
    s.rstn = 1'b1;
    return s;
  endfunction

  task automatic push_reset();
    stim_t s;
    s = idle_cycle();
    s.rstn = 1'b0;
    q.push_back(s);
  endtask

  // Burst data is start+i, shifted by skew from beat cidx on, so only beat cidx breaks the pattern.
  task automatic write_burst(input int len, input int d, input int cidx, input logic [31:0] skew,
                             input int lflip, input bit binj, input logic [31:0] start, input int abort);
    stim_t s;
    logic [31:0] dat [16];
    logic lst [16];
    bit resp;
    for (int i = 0; i <= len; i++) begin
      dat[i] = start + 32'(i) + ((cidx >= 0 && i >= cidx) ? skew : 32'd0);
      lst[i] = (i == len);
    end
    if (lflip >= 0) lst[lflip] = !lst[lflip];
    for (int k = 1; k <= d; k++) begin
      s = idle_cycle(); s.awvalid = 1'b1; s.awready = (k == d); s.awlen = 8'(len);
      q.push_back(s);
    end
    if (binj) begin
      s = idle_cycle(); s.bready = 1'b1; s.exp[F_WPH] = 1'b1; q.push_back(s);
    end
    resp = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == abort) begin push_reset(); return; end
      if ($urandom_range(0, 2) == 0) q.push_back(idle_cycle());
      s = idle_cycle(); s.wvalid = 1'b1; s.wready = 1'b1; s.wlast = lst[i]; s.wdata = dat[i];
      s.exp[F_WD]  = (i > 0) ? (dat[i] != 32'(dat[i-1] + INC)) : 1'b0;
      s.exp[F_WL]  = (lst[i] != (i == len));
      s.exp[F_WPH] = resp;
      if (lst[i]) resp = 1'b1;
      q.push_back(s);
    end
    s = idle_cycle(); s.bvalid = 1'b1; s.bready = 1'b1; s.exp[F_WPH] = !resp;
    q.push_back(s);
    if (!resp) push_reset();
  endtask

  task automatic read_burst(input int len, input int d, input int cidx, input logic [31:0] skew,
                            input int lflip, input bit ovinj, input logic [31:0] start);
    stim_t s;
    logic [31:0] dat [16];
    logic lst [16];
    bit busy;
    for (int i = 0; i <= len; i++) begin
      dat[i] = start + 32'(i) + ((cidx >= 0 && i >= cidx) ? skew : 32'd0);
      lst[i] = (i == len);
    end
    if (lflip >= 0) lst[lflip] = !lst[lflip];
    if (ovinj) begin
      s = idle_cycle(); s.arready = 1'b1; s.rready = 1'b1;
      s.exp[F_ARN] = 1'b1; s.exp[F_RPH] = 1'b1; s.exp[F_ARHS] = 1'b1;
      q.push_back(s);
      q.push_back(idle_cycle());
    end
    for (int k = 1; k <= d; k++) begin
      s = idle_cycle(); s.arvalid = 1'b1; s.arready = (k == d); s.arlen = 8'(len);
      q.push_back(s);
    end
    busy = 1'b1;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 2) == 0) q.push_back(idle_cycle());
      s = idle_cycle(); s.rvalid = 1'b1; s.rready = 1'b1; s.rlast = lst[i]; s.rdata = dat[i];
      s.exp[F_RD] = (i > 0) ? (dat[i] != 32'(dat[i-1] + INC)) : 1'b0;
      s.exp[F_RL] = (lst[i] != (i == len));
      if (lst[i]) busy = 1'b0;
      q.push_back(s);
    end
    if (busy) push_reset();
  endtask

  // Drop before ready is flagged when VALID falls; past MAX_ACK only the timeout is flagged.
  task automatic aw_timeout(input int t);
    stim_t s;
    for (int k = 1; k <= t; k++) begin
      s = idle_cycle(); s.awvalid = 1'b1; s.exp[F_AWHS] = (k == MAX_ACK + 1);
      q.push_back(s);
    end
    s = idle_cycle(); s.exp[F_AWHS] = (t <= MAX_ACK);
    q.push_back(s);
  endtask

  task automatic drive(input stim_t s);
    ARESETN = s.rstn;
    bus.AWVALID = s.awvalid; bus.AWREADY = s.awready; bus.AWLEN = s.awlen;
    bus.WVALID = s.wvalid; bus.WREADY = s.wready; bus.WLAST = s.wlast; bus.WDATA = s.wdata;
    bus.BVALID = s.bvalid; bus.BREADY = s.bready;
    bus.ARVALID = s.arvalid; bus.ARREADY = s.arready; bus.ARLEN = s.arlen;
    bus.RVALID = s.rvalid; bus.RREADY = s.rready; bus.RLAST = s.rlast; bus.RDATA = s.rdata;
  endtask

  initial begin
    logic [8:0] got, exp;
    bit sticky_m;
    int len, kind;
    n_run = 0;
    n_fail = 0;
    repeat (3) push_reset();
    q.push_back(idle_cycle());

    write_burst(3, 2, -1, 32'd0, -1, 1'b0, 32'h10, -1);
    q.push_back(idle_cycle());
    read_burst(3, 1, 2, 32'd1, -1, 1'b0, 32'd5);
    repeat (2) q.push_back(idle_cycle());
    push_reset();
    aw_timeout(33);
    aw_timeout(5);
    write_burst(3, 1, -1, 32'd0, 1, 1'b0, 32'h100, -1);
    q.push_back(idle_cycle());
    read_burst(0, 1, -1, 32'd0, 0, 1'b0, 32'h7);
    read_burst(2, 3, -1, 32'd0, -1, 1'b1, 32'h20);
    write_burst(2, 1, -1, 32'd0, -1, 1'b1, 32'h30, -1);
    push_reset();
    write_burst(1, 1, -1, 32'd0, -1, 1'b0, 32'hFFFF_FFFF, -1);
    write_burst(3, 2, -1, 32'd0, -1, 1'b0, 32'h40, 2);
    write_burst(3, 2, -1, 32'd0, -1, 1'b0, 32'h50, -1);
    q.push_back(idle_cycle());

    for (int n = 0; n < 70; n++) begin
      kind = $urandom_range(0, 4);
      len  = $urandom_range(0, 7);
      if (kind <= 1)
        write_burst(len, ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAX_ACK) : $urandom_range(1, 3),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1, 32'($urandom_range(1, 255)),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1, ($urandom_range(0, 4) == 0),
                    $urandom(), ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1);
      else if (kind <= 3)
        read_burst(len, ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAX_ACK) : $urandom_range(1, 3),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1, 32'($urandom_range(1, 255)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1, ($urandom_range(0, 4) == 0),
                   $urandom());
      else
        aw_timeout($urandom_range(1, 40));
      repeat ($urandom_range(1, 2)) q.push_back(idle_cycle());
    end

    sticky_m = 1'b0;
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge ACLK);
      #1;
      exp = q[i].rstn ? q[i].exp : 9'd0;
      sticky_m = q[i].rstn ? (sticky_m || (|exp)) : 1'b0;
      got = {fire_aw_hs, fire_ar_hs, fire_wdata, fire_rdata, fire_ar_never,
             fire_wlast, fire_rlast, fire_wphase, fire_rphase};
      check_eq($sformatf("fires@%0d", i), 32'(got), 32'(exp));
      check_eq($sformatf("sticky@%0d", i), 32'(err_sticky), 32'(sticky_m));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
